// File: rtl/bulls_cows_pkg.sv
// rtl/bulls_cows_pkg.sv - shared state encoding and digit limit for the bulls & cows core
package bulls_cows_pkg;

  typedef enum logic [2:0] {
    SET_SECRET = 3'd0,
    GUESS      = 3'd1,
    EVAL       = 3'd2,
    SCORE      = 3'd3,
    DONE       = 3'd4
  } bc_state_t;

  localparam int MAX_DIGIT = 9;

endpackage

// File: rtl/bc_entry_check.sv
// rtl/bc_entry_check.sv - combinational range and duplicate-digit check of a code entry
module bc_entry_check
  import bulls_cows_pkg::*;
#(
  parameter int NDIG = 4,
  parameter int DW   = 4
) (
  input  logic [NDIG*DW-1:0] code,
  output logic               valid
);

  always_comb begin
    valid = 1'b1;
    for (int i = 0; i < NDIG; i++) begin
      if (code[i*DW +: DW] > DW'(MAX_DIGIT)) valid = 1'b0;
      for (int j = i + 1; j < NDIG; j++) begin
        if (code[i*DW +: DW] == code[j*DW +: DW]) valid = 1'b0;
      end
    end
  end

endmodule

// File: rtl/bulls_cows_engine.sv
// rtl/bulls_cows_engine.sv - bulls & cows game core: secret/guess entry, serial scoring, attempt count
module bulls_cows_engine
  import bulls_cows_pkg::*;
#(
  parameter int NDIG         = 4,
  parameter int DW           = 4,
  parameter int MAX_ATTEMPTS = 10
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       confirma,
  input  logic [NDIG*DW-1:0]         SW,
  output logic [$clog2(NDIG+1)-1:0]  bulls,
  output logic [$clog2(NDIG+1)-1:0]  cows,
  output logic [7:0]                 attempts,
  output logic [2:0]                 state_o,
  output logic                       result_valid,
  output logic                       input_error,
  output logic                       win,
  output logic                       lose
);

  localparam int CW = $clog2(NDIG + 1);
  localparam int IW = $clog2(NDIG);

  bc_state_t           state_q, state_d;
  logic                conf_q;
  logic                confirm_evt;
  logic                entry_ok;
  logic [NDIG*DW-1:0]  secret;
  logic [NDIG*DW-1:0]  guess;
  logic [IW-1:0]       idx;
  logic [CW-1:0]       bacc, cacc;
  logic [DW-1:0]       g_dig;
  logic                hit_bull, hit_cow;
  logic [7:0]          attempts_inc;
  logic                win_now, lose_now;

  assign confirm_evt  = confirma & ~conf_q;
  assign state_o      = state_q;
  assign attempts_inc = attempts + 8'd1;
  assign win_now      = (bacc == CW'(NDIG));
  assign lose_now     = (attempts_inc == 8'(MAX_ATTEMPTS));

  bc_entry_check #(
    .NDIG (NDIG),
    .DW   (DW)
  ) u_entry_check (
    .code  (SW),
    .valid (entry_ok)
  );

  // One guess digit per cycle against every secret digit; secret digits are distinct.
  always_comb begin
    g_dig    = '0;
    hit_bull = 1'b0;
    hit_cow  = 1'b0;
    for (int i = 0; i < NDIG; i++) begin
      if (IW'(i) == idx) g_dig = guess[i*DW +: DW];
    end
    for (int j = 0; j < NDIG; j++) begin
      if (secret[j*DW +: DW] == g_dig) begin
        if (IW'(j) == idx) hit_bull = 1'b1;
        else               hit_cow  = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      SET_SECRET: if (confirm_evt && entry_ok) state_d = GUESS;
      GUESS:      if (confirm_evt && entry_ok) state_d = EVAL;
      EVAL:       if (idx == IW'(NDIG - 1))    state_d = SCORE;
      SCORE: begin
        if (win_now || lose_now) state_d = DONE;
        else                     state_d = GUESS;
      end
      DONE:       state_d = DONE;
      default:    state_d = SET_SECRET;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= SET_SECRET;
      conf_q       <= 1'b1;
      secret       <= '0;
      guess        <= '0;
      idx          <= '0;
      bacc         <= '0;
      cacc         <= '0;
      bulls        <= '0;
      cows         <= '0;
      attempts     <= '0;
      result_valid <= 1'b0;
      input_error  <= 1'b0;
      win          <= 1'b0;
      lose         <= 1'b0;
    end else begin
      state_q      <= state_d;
      conf_q       <= confirma;
      result_valid <= 1'b0;
      case (state_q)
        SET_SECRET: begin
          if (confirm_evt) begin
            if (entry_ok) begin
              secret      <= SW;
              input_error <= 1'b0;
            end else begin
              input_error <= 1'b1;
            end
          end
        end
        GUESS: begin
          if (confirm_evt) begin
            if (entry_ok) begin
              guess       <= SW;
              input_error <= 1'b0;
              bacc        <= '0;
              cacc        <= '0;
              idx         <= '0;
            end else begin
              input_error <= 1'b1;
            end
          end
        end
        EVAL: begin
          if (hit_bull)     bacc <= bacc + CW'(1);
          else if (hit_cow) cacc <= cacc + CW'(1);
          idx <= idx + IW'(1);
        end
        SCORE: begin
          bulls        <= bacc;
          cows         <= cacc;
          result_valid <= 1'b1;
          attempts     <= attempts_inc;
          if (win_now)       win  <= 1'b1;
          else if (lose_now) lose <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/bulls_cows_engine.md
Name: bulls_cows_engine

Overview:
Parametrised Bulls & Cows game core for the Nexys A7 build. Player 1 enters the secret on the switches and player 2 then guesses it. The block checks every entry, scores guesses one digit per cycle and counts attempts. It reports win or lose to the board top, which drives the LEDs and the 7-segment multiplexer.

Parameters:
NDIG, 4, digits per code; legal range 2..8.
DW, 4, bits per digit; digits must be 0..MAX_DIGIT.
MAX_ATTEMPTS, 10, guesses allowed before lose; legal range 1..255.

Ports:
clock  in  1  system clock (single clock domain).
reset  in  1  synchronous, active-high; restarts the game.
confirma  in  1  debounced confirm button level; edge-detected internally.
SW  in  NDIG*DW  code entry; digit i = SW[i*DW +: DW], digit 0 rightmost.
bulls  out  $clog2(NDIG+1)  right digit in the right position.
cows  out  $clog2(NDIG+1)  right digit in the wrong position.
attempts  out  8  guesses scored so far.
state_o  out  3  current FSM state (bc_state_t encoding).
result_valid  out  1  one-cycle pulse when bulls/cows update.
input_error  out  1  last confirmed entry was rejected.
win  out  1  sticky until reset.
lose  out  1  sticky until reset.

Behaviour:
- Reset is synchronous: state=SET_SECRET and every output is 0. The internal confirm-edge register resets to 1, so a button held through reset needs a release and press before it counts.
- Confirm event: confirma is 1 now and was 0 last cycle. An event is accepted only in SET_SECRET or GUESS; in every other state it is dropped, not queued.
- Entry check (combinational) fails if any digit is >MAX_DIGIT (9) or two digits are equal.
- SET_SECRET:
  - Valid event: latch SW as secret, clear input_error, go to GUESS.
  - Invalid event: input_error<=1, stay.
- GUESS:
  - Valid event: latch SW as guess, clear input_error, zero the bull/cow accumulators, idx<=0, go to EVAL.
  - Invalid event: input_error<=1, attempts unchanged, stay.
- EVAL takes NDIG cycles. Per cycle, for guess digit idx:
  - bull if guess[idx]==secret[idx];
  - otherwise cow if it equals any secret[j] with j!=idx.
  - idx increments; after idx==NDIG-1 go to SCORE.
- SCORE (1 cycle):
  - Copy accumulators to bulls/cows, pulse result_valid, attempts+1.
  - bulls==NDIG: win<=1, go to DONE. Win takes priority over lose on the final attempt.
  - Else if the new attempts==MAX_ATTEMPTS: lose<=1, go to DONE.
  - Else go to GUESS.
- Latency: confirm edge cycle -> result_valid is NDIG+2 cycles (edge registered, NDIG EVAL cycles, SCORE).
- bulls and cows hold their value until the next SCORE; they are not cleared on entering EVAL.
- DONE: all inputs ignored; only reset leaves.
- Reset in any state, including mid-EVAL, aborts immediately with no result_valid pulse.
- attempts cannot exceed MAX_ATTEMPTS.
- bulls+cows<=NDIG always; the verification engineer asserts this.

Decomposition:
- Package bulls_cows_pkg:
  - typedef enum logic[2:0] bc_state_t {SET_SECRET=0, GUESS=1, EVAL=2, SCORE=3, DONE=4};
  - localparam MAX_DIGIT=9.
- One sub-module, bc_entry_check: combinational range and duplicate checker, parametrised by NDIG/DW, output valid. It is instantiated once and shared by the SET_SECRET and GUESS paths.

Test Plan:
- Secret 1234 accepted; guess 1243 -> result_valid NDIG+2 cycles after edge, bulls=2, cows=2, attempts=1.
- Guess 5678 -> bulls=0, cows=0. Guess 1234 -> bulls=4, win=1, state_o=DONE. Later confirms with SW=0000 change nothing.
- Secret 1123, then 12A4 -> input_error=1 each time, state stays SET_SECRET. Then 9870 accepted -> input_error=0.
- MAX_ATTEMPTS=3, secret 1234: guesses 5678, 5679, 5670 -> lose=1 after the third, attempts=3. Rerun with 1234 as the third guess -> win=1, lose=0.
- confirma held high across reset -> no event. Confirm pulses during EVAL -> ignored, attempts rises by exactly 1.
- Reset asserted on the 2nd EVAL cycle -> next cycle all outputs 0, state_o=SET_SECRET, no result_valid. Rerun with NDIG=6, DW=4, secret 012345, guess 543210 -> bulls=0, cows=6.
